// File: rtl/aes_pkg.sv
// Shared AES constants and state type for the inverse-cipher datapath stages.
package aes_pkg;
  localparam int STATE_W   = 128;
  localparam int NUM_BYTES = 16;

  typedef logic [STATE_W-1:0] state_t;

  // Byte 0 sits in the top byte lane of the state word.
  function automatic int byte_lsb(input int k);
    return STATE_W - 8 - 8 * k;
  endfunction
endpackage

// File: rtl/inv_shift_rows_perm.sv
// Combinational InvShiftRows: row r of the column-major state rotates right by r.
module inv_shift_rows_perm
  import aes_pkg::*;
(
  input  state_t i_state,
  output state_t o_state
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign o_state[byte_lsb(r + 4*c) +: 8] = i_state[byte_lsb(r + 4*((c - r + 4) % 4)) +: 8];
    end
  end
endmodule

// File: rtl/inv_shift_rows_stage.sv
// InvShiftRows pipeline stage with valid/ready handshake and accepted-block counter.
// Define INV_SHIFT_ROWS_SKID_EN for a main+skid buffer with a registered ready_o.
module inv_shift_rows_stage
  import aes_pkg::*;
#(
  parameter int size  = 16,
  parameter int tag_w = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [size*8-1:0]   block_i,
  input  logic [tag_w-1:0]    tag_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [size*8-1:0]   shifted_block_o,
  output logic [tag_w-1:0]    tag_o,
  input  logic                ready_i,
  output logic [15:0]         count_o
);
  state_t             w_shifted;
  logic               w_in, w_out;
  logic               r_v;
  logic [size*8-1:0]  r_blk;
  logic [tag_w-1:0]   r_tag;
  logic [15:0]        r_cnt;

  inv_shift_rows_perm u_perm (
    .i_state (block_i),
    .o_state (w_shifted)
  );

  assign w_in  = v_i && ready_o;
  assign w_out = r_v && ready_i;

  assign v_o             = r_v;
  assign shifted_block_o = r_blk;
  assign tag_o           = r_tag;
  assign count_o         = r_cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_cnt <= '0;
    else if (w_in)  r_cnt <= r_cnt + 16'd1;
  end

`ifdef INV_SHIFT_ROWS_SKID_EN
  logic               r_sv, r_rdy;
  logic [size*8-1:0]  r_sblk;
  logic [tag_w-1:0]   r_stag;
  logic               w_sv_nxt;

  // Skid fills only when main is occupied and not draining; it empties on any drain.
  assign w_sv_nxt = r_sv ? !w_out : (w_in && r_v && !w_out);
  assign ready_o  = r_rdy;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_v    <= 1'b0;
      r_blk  <= '0;
      r_tag  <= '0;
      r_sv   <= 1'b0;
      r_sblk <= '0;
      r_stag <= '0;
      r_rdy  <= 1'b1;
    end else begin
      if (w_out) begin
        if (r_sv) begin
          r_blk <= r_sblk;
          r_tag <= r_stag;
        end else begin
          r_v <= 1'b0;
        end
      end
      if (w_in) begin
        if (!r_v || w_out) begin
          r_blk <= w_shifted;
          r_tag <= tag_i;
          r_v   <= 1'b1;
        end else begin
          r_sblk <= w_shifted;
          r_stag <= tag_i;
        end
      end
      r_sv  <= w_sv_nxt;
      r_rdy <= !w_sv_nxt;
    end
  end
`else
  assign ready_o = !r_v || ready_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_v   <= 1'b0;
      r_blk <= '0;
      r_tag <= '0;
    end else if (w_in) begin
      r_v   <= 1'b1;
      r_blk <= w_shifted;
      r_tag <= tag_i;
    end else if (ready_i) begin
      r_v <= 1'b0;
    end
  end
`endif
endmodule
